sr_drive_ctrl: RTL and testbench
================================

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 4, meaning S/R pulse width in clock cycles (legal 1..255).
REQ-002 SHALL have parameter DEAD_CYC, default 2, meaning the all-low gap after every pulse in clock cycles (legal 1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge triggered.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port set_req, input, 1, request for a set pulse on S.
REQ-006 SHALL have port clr_req, input, 1, request for a reset pulse on R.
REQ-007 SHALL have port req_ready, output, 1, high when a request can be accepted this cycle.
REQ-008 SHALL have port S, output, 1, registered set drive to the downstream sr_latch S input.
REQ-009 SHALL have port R, output, 1, registered reset drive to the downstream sr_latch R input.
REQ-010 SHALL have port busy, output, 1, high while a pulse, dead gap or pending request exists.
REQ-011 SHALL have port state_q, output, 1, shadow of the expected latch Q value.
REQ-012 SHALL have port conflict, output, 1, single-cycle flag for a rejected simultaneous set/clr request.

Function
REQ-013 SHALL accept a request on a rising edge where req_ready=1 and exactly one of set_req/clr_req is 1.
REQ-014 SHALL NOT accept anything when set_req=clr_req=1 with req_ready=1; instead conflict SHALL be 1 on the next cycle only, with S, R, FSM and pending slot unchanged.
REQ-015 SHALL implement FSM states IDLE, DRIVE, DEAD; reset state IDLE.
REQ-016 IDLE: on an accepted request with no pending entry, SHALL move to DRIVE with S (set) or R (clr) high from the next cycle.
REQ-017 DRIVE: SHALL hold exactly one of S/R high for exactly PULSE_CYC cycles, then move to DEAD.
REQ-018 DEAD: SHALL hold S=R=0 for exactly DEAD_CYC cycles; then, if the pending slot is valid, SHALL go directly to DRIVE with that request (pulses spaced by exactly DEAD_CYC cycles), else to IDLE.
REQ-019 SHALL provide a one-entry pending slot; requests accepted while in DRIVE or DEAD SHALL be stored there.
REQ-020 req_ready SHALL equal !pend_valid && !rst.
REQ-021 S and R SHALL never be 1 in the same cycle under any input sequence.
REQ-022 state_q SHALL update (1 for set, 0 for clr) on the edge ending the last DRIVE cycle of that pulse.
REQ-023 Redundant requests (set while state_q=1, clr while state_q=0) SHALL still produce a full pulse.
REQ-024 busy SHALL be 1 whenever the state is not IDLE or pend_valid=1.
REQ-025 The pulse/dead counter SHALL be 8 bits, load PULSE_CYC-1 or DEAD_CYC-1, and count down to 0 without wrap.
REQ-026 Requests presented while rst=1 SHALL be ignored.

Reset
REQ-027 On any edge with rst=1: S=0, R=0, state_q=0, conflict=0, busy=0, pend_valid=0, FSM=IDLE, counter=0.
REQ-028 Reset mid-pulse or mid-gap SHALL drop S/R to 0 on that edge and discard any pending request; no pulse resumes after reset.
REQ-029 req_ready SHALL be 1 on the first cycle after rst deasserts.

Verification (PULSE_CYC=4, DEAD_CYC=2)
REQ-030 Reset, then set_req for 1 cycle at cycle 0 -> S=1 cycles 1-4, R=0 throughout, state_q=1 from cycle 5, busy low from cycle 7.
REQ-031 set_req at cycle 0, clr_req at cycle 2 -> S=1 cycles 1-4, gap cycles 5-6, R=1 cycles 7-10, req_ready=0 cycles 3-6, state_q 1 then 0 at cycle 11.
REQ-032 set_req=clr_req=1 at cycle 0 while idle -> conflict=1 at cycle 1 only, S=R=0, busy=0.
REQ-033 Three back-to-back requests during a pulse -> second stored, third not accepted while req_ready=0, exactly two pulses emitted.
REQ-034 rst=1 at cycle 2 of a set pulse with a clr pending -> S=0 from cycle 3, no R pulse, state_q=0.
REQ-035 Randomised set/clr/conflict stream of 1000 cycles -> S&R never 1, every pulse exactly 4 cycles, gaps at least 2 cycles.

Source files
------------

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: sends fixed-width S/R pulses to a downstream SR latch.
// Each pulse is followed by an all-low dead gap. One request can wait.
module sr_drive_ctrl #(
    parameter int PULSE_CYC = 4,
    parameter int DEAD_CYC  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic req_ready,
    output logic S,
    output logic R,
    output logic busy,
    output logic state_q,
    output logic conflict
);

    typedef enum logic [1:0] {IDLE, DRIVE, DEAD} st_t;

    localparam logic [7:0] P_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] D_LD = 8'(DEAD_CYC - 1);

    st_t        st, st_n;
    logic [7:0] cnt, cnt_n;
    logic       kind, kind_n;
    logic       pend_v, pend_v_n;
    logic       pend_k, pend_k_n;
    logic       s_n, r_n, sq_n, conf_n;
    logic       acc, go_k;

    assign req_ready = !pend_v && !rst;
    assign acc       = req_ready && (set_req ^ clr_req);
    assign busy      = (st != IDLE) || pend_v;
    // The held request wins over a new one arriving in the same cycle
    assign go_k      = pend_v ? pend_k : set_req;

    // Next-state logic: pulse timing, pending slot and output drive
    always_comb begin
        st_n     = st;
        cnt_n    = cnt;
        kind_n   = kind;
        pend_v_n = pend_v;
        pend_k_n = pend_k;
        s_n      = 1'b0;
        r_n      = 1'b0;
        sq_n     = state_q;
        conf_n   = req_ready && set_req && clr_req;
        unique case (st)
            IDLE: begin
                if (acc) begin
                    st_n   = DRIVE;
                    cnt_n  = P_LD;
                    kind_n = set_req;
                    s_n    = set_req;
                    r_n    = !set_req;
                end
            end
            DRIVE: begin
                if (acc) begin
                    pend_v_n = 1'b1;
                    pend_k_n = set_req;
                end
                if (cnt == 8'd0) begin
                    st_n  = DEAD;
                    cnt_n = D_LD;
                    sq_n  = kind;
                end else begin
                    cnt_n = cnt - 8'd1;
                    s_n   = kind;
                    r_n   = !kind;
                end
            end
            DEAD: begin
                if (cnt == 8'd0) begin
                    // Gap over: start the waiting pulse straight away
                    if (pend_v || acc) begin
                        st_n     = DRIVE;
                        cnt_n    = P_LD;
                        kind_n   = go_k;
                        pend_v_n = 1'b0;
                        s_n      = go_k;
                        r_n      = !go_k;
                    end else begin
                        st_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                    if (acc) begin
                        pend_v_n = 1'b1;
                        pend_k_n = set_req;
                    end
                end
            end
            default: begin
                st_n  = IDLE;
                cnt_n = 8'd0;
            end
        endcase
    end

    // State registers; reset clears everything including the pending slot
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            cnt      <= 8'd0;
            kind     <= 1'b0;
            pend_v   <= 1'b0;
            pend_k   <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            state_q  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            st       <= st_n;
            cnt      <= cnt_n;
            kind     <= kind_n;
            pend_v   <= pend_v_n;
            pend_k   <= pend_k_n;
            S        <= s_n;
            R        <= r_n;
            state_q  <= sq_n;
            conflict <= conf_n;
        end
    end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: directed vector table plus a random stream
// checked against a pulse-schedule model.
module tb_sr_drive_ctrl;

    localparam int P = 4;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst, set_req, clr_req;
    logic req_ready, S, R, busy, state_q, conflict;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_drive_ctrl #(.PULSE_CYC(P), .DEAD_CYC(D)) dut (
        .clk(clk),
        .rst(rst),
        .set_req(set_req),
        .clr_req(clr_req),
        .req_ready(req_ready),
        .S(S),
        .R(R),
        .busy(busy),
        .state_q(state_q),
        .conflict(conflict)
    );

    typedef struct {
        logic rs, st, cl;
        logic s, r, rdy, bsy, sq, cf;
    } vec_t;

    vec_t vecs[$];

    typedef struct {
        int start;
        bit k;
    } pl_t;

    pl_t q[$];

    task automatic add(input logic rs, st, cl,
                       input logic s, r, rdy, bsy, sq, cf);
        vec_t v;
        v.rs = rs; v.st = st; v.cl = cl;
        v.s = s; v.r = r; v.rdy = rdy;
        v.bsy = bsy; v.sq = sq; v.cf = cf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int cyc,
                       input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d got %0b want %0b",
                     nm, cyc, a, e);
        end
    endtask

    task automatic chk_all(input int cyc,
                           input logic s, r, rdy, bsy, sq, cf);
        chk("S", cyc, S, s);
        chk("R", cyc, R, r);
        chk("req_ready", cyc, req_ready, rdy);
        chk("busy", cyc, busy, bsy);
        chk("state_q", cyc, state_q, sq);
        chk("conflict", cyc, conflict, cf);
        chk("s_and_r", cyc, S & R, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int lst, bend, st, r;
        bit sq, cm, rs, sr, cr, es, er, erdy;

        // reset state
        add(1,0,0, 0,0,0,0,0,0);
        // single set pulse
        add(0,1,0, 0,0,1,0,0,0);
        repeat (4) add(0,0,0, 1,0,1,1,0,0);
        repeat (2) add(0,0,0, 0,0,1,1,1,0);
        repeat (2) add(0,0,0, 0,0,1,0,1,0);
        // redundant set, then clr queued behind it
        add(0,1,0, 0,0,1,0,1,0);
        add(0,0,0, 1,0,1,1,1,0);
        add(0,0,1, 1,0,1,1,1,0);
        repeat (2) add(0,0,0, 1,0,0,1,1,0);
        repeat (2) add(0,0,0, 0,0,0,1,1,0);
        repeat (4) add(0,0,0, 0,1,1,1,1,0);
        repeat (2) add(0,0,0, 0,0,1,1,0,0);
        add(0,0,0, 0,0,1,0,0,0);
        // conflict while idle
        add(0,1,1, 0,0,1,0,0,0);
        add(0,0,0, 0,0,1,0,0,1);
        add(0,0,0, 0,0,1,0,0,0);
        // three requests during a pulse
        add(0,1,0, 0,0,1,0,0,0);
        add(0,0,1, 1,0,1,1,0,0);
        add(0,1,0, 1,0,0,1,0,0);
        add(0,1,1, 1,0,0,1,0,0);
        add(0,0,0, 1,0,0,1,0,0);
        repeat (2) add(0,0,0, 0,0,0,1,1,0);
        repeat (4) add(0,0,0, 0,1,1,1,1,0);
        repeat (2) add(0,0,0, 0,0,1,1,0,0);
        add(0,0,0, 0,0,1,0,0,0);
        // reset mid-pulse with clr pending
        add(0,1,0, 0,0,1,0,0,0);
        add(0,0,1, 1,0,1,1,0,0);
        add(1,0,0, 1,0,0,1,0,0);
        repeat (7) add(0,0,0, 0,0,1,0,0,0);
        // request during reset is ignored
        add(1,1,0, 0,0,0,0,0,0);
        repeat (3) add(0,0,0, 0,0,1,0,0,0);

        rst = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rs;
            set_req = vecs[i].st;
            clr_req = vecs[i].cl;
            #1;
            chk_all(i, vecs[i].s, vecs[i].r, vecs[i].rdy,
                    vecs[i].bsy, vecs[i].sq, vecs[i].cf);
            tick();
        end

        // random stream against a schedule of pulse start times
        rst = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        tick();
        q.delete();
        sq = 0;
        cm = 0;
        lst = -1000;
        bend = -1;
        for (int t = 0; t < 1000; t++) begin
            rs = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 7);
            sr = (r == 0 || r == 1 || r == 6);
            cr = (r == 2 || r == 3 || r == 6);
            rst = rs;
            set_req = sr;
            clr_req = cr;
            #1;
            while (q.size() > 0 && q[0].start + P <= t) begin
                sq = q[0].k;
                void'(q.pop_front());
            end
            es = q.size() > 0 && q[0].start <= t && q[0].k;
            er = q.size() > 0 && q[0].start <= t && !q[0].k;
            erdy = !rs && !(q.size() > 0 && q[q.size()-1].start > t);
            chk_all(10000 + t, es, er, erdy, t <= bend, sq, cm);
            if (rs) begin
                q.delete();
                sq = 0;
                cm = 0;
                lst = -1000;
                bend = -1;
            end else begin
                cm = erdy && sr && cr;
                if (erdy && (sr ^ cr)) begin
                    st = (t + 1 > lst + D + 1) ? t + 1 : lst + D + 1;
                    q.push_back('{start: st, k: sr});
                    lst = st + P - 1;
                    bend = lst + D;
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
